// File: rtl/kronos_types.sv
// Shared writeback types for the Kronos decode-stage register-write path.
package kronos_types;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_EX,
      WB_LSU
   } wb_grant_e;

endpackage

// File: rtl/kronos_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with
// lock-over-clear priority and a sticky protocol error flag.
module kronos_scoreboard
   import kronos_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        lock_en,
   input  logic [4:0]  lock_rd,
   input  logic        clr_en,
   input  logic [4:0]  clr_rd,
   output logic [31:0] busy,
   output logic        sb_err
);

   logic        lock_hit;
   logic        clr_hit;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;
   logic [31:0] busy_nxt;
   logic        waw_err;
   logic        unlocked_err;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      lock_hit     = lock_en && (lock_rd != 5'd0);
      clr_hit      = clr_en && (clr_rd != 5'd0);
      set_mask     = '0;
      clr_mask     = '0;
      if (lock_hit) set_mask[lock_rd] = 1'b1;
      if (clr_hit)  clr_mask[clr_rd]  = 1'b1;
      // Clear first, then set: a same-index lock survives the writeback.
      busy_nxt     = (busy & ~clr_mask) | set_mask;
      busy_nxt[0]  = 1'b0;
      waw_err      = lock_hit && busy[lock_rd] && !(clr_hit && (clr_rd == lock_rd));
      unlocked_err = clr_hit && !busy[clr_rd];
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= '0;
         sb_err <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (waw_err || unlocked_err) sb_err <= 1'b1;
      end
   end

endmodule

// File: rtl/kronos_wb_arbiter.sv
// Writeback arbiter owning the decode-stage register-file write port: LSU
// priority with an EX starvation limit, registered write, and hazard scoreboard.
module kronos_wb_arbiter
   import kronos_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_vld,
   output logic        ex_rdy,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_data,
   input  logic        ls_vld,
   output logic        ls_rdy,
   input  logic [4:0]  ls_rd,
   input  logic [31:0] ls_data,
   input  logic        lock_en,
   input  logic [4:0]  lock_rd,
   output logic [31:0] busy,
   output logic        regwr_en,
   output logic [4:0]  regwr_sel,
   output logic [31:0] regwr_data,
   output logic        sb_err
);

   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   wb_grant_e        grant;
   wb_req_t          req;
   logic             gnt_vld;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_nxt;

   always_comb begin
      grant = WB_NONE;
      if (ex_vld && ls_vld) grant = (starve_cnt == CNT_MAX) ? WB_EX : WB_LSU;
      else if (ex_vld)      grant = WB_EX;
      else if (ls_vld)      grant = WB_LSU;

      ex_rdy  = (grant == WB_EX);
      ls_rdy  = (grant == WB_LSU);
      gnt_vld = (grant != WB_NONE);

      req = '{rd: ls_rd, data: ls_data};
      if (grant == WB_EX) req = '{rd: ex_rd, data: ex_data};

      // Counts only LSU wins that made a waiting EX request wait longer.
      starve_nxt = starve_cnt;
      if (!ex_vld || (grant == WB_EX))                      starve_nxt = '0;
      else if ((grant == WB_LSU) && (starve_cnt != CNT_MAX)) starve_nxt = starve_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         regwr_en   <= 1'b0;
         regwr_sel  <= '0;
         regwr_data <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         regwr_en   <= gnt_vld && (req.rd != 5'd0);
         if (gnt_vld) begin
            regwr_sel  <= req.rd;
            regwr_data <= req.data;
         end
      end
   end

   kronos_scoreboard u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .lock_en (lock_en),
      .lock_rd (lock_rd),
      .clr_en  (gnt_vld),
      .clr_rd  (req.rd),
      .busy    (busy),
      .sb_err  (sb_err)
   );

endmodule

// File: tb/tb_kronos_wb_arbiter.sv
// Directed bench for kronos_wb_arbiter: expected register writes are queued
// as requests are driven and compared one edge later.
module tb_kronos_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_vld, ls_vld, lock_en;
   logic        ex_rdy, ls_rdy;
   logic [4:0]  ex_rd, ls_rd, lock_rd;
   logic [31:0] ex_data, ls_data;
   logic [31:0] busy;
   logic        regwr_en, sb_err;
   logic [4:0]  regwr_sel;
   logic [31:0] regwr_data;

   typedef struct packed {
      logic        en;
      logic [4:0]  sel;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [4:0]  last_sel;
   logic [31:0] last_data;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   kronos_wb_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .ex_vld     (ex_vld),
      .ex_rdy     (ex_rdy),
      .ex_rd      (ex_rd),
      .ex_data    (ex_data),
      .ls_vld     (ls_vld),
      .ls_rdy     (ls_rdy),
      .ls_rd      (ls_rd),
      .ls_data    (ls_data),
      .lock_en    (lock_en),
      .lock_rd    (lock_rd),
      .busy       (busy),
      .regwr_en   (regwr_en),
      .regwr_sel  (regwr_sel),
      .regwr_data (regwr_data),
      .sb_err     (sb_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_grant(input logic [4:0] rd, input logic [31:0] data);
      exp_q.push_back('{en: (rd != 5'd0), sel: rd, data: data});
      last_sel  = rd;
      last_data = data;
   endtask

   task automatic expect_idle();
      exp_q.push_back('{en: 1'b0, sel: last_sel, data: last_data});
   endtask

   task automatic check_rdy(input string tag, input logic ex_exp, input logic ls_exp);
      #1;
      check({tag, ".ex_rdy"}, 32'(ex_rdy), 32'(ex_exp));
      check({tag, ".ls_rdy"}, 32'(ls_rdy), 32'(ls_exp));
   endtask

   // Advance one edge and compare the registered write against the queue head.
   task automatic tick(input string tag);
      wr_t e;
      @(posedge clk);
      #1;
      vectors++;
      assert (exp_q.size() != 0) else begin
         miscompares++;
         $error("FAIL %s.queue: observed empty expected entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, ".regwr_en"},   32'(regwr_en),  32'(e.en));
         check({tag, ".regwr_sel"},  32'(regwr_sel), 32'(e.sel));
         check({tag, ".regwr_data"}, regwr_data,     e.data);
      end
   endtask

   task automatic lock_cycle(input logic [4:0] rd);
      lock_en = 1'b1;
      lock_rd = rd;
      expect_idle();
      tick("lock");
      lock_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      ex_vld = 1'b0; ls_vld = 1'b0; lock_en = 1'b0;
      ex_rd = '0; ls_rd = '0; lock_rd = '0;
      ex_data = '0; ls_data = '0;
      last_sel = '0; last_data = '0;

      repeat (2) @(posedge clk);
      #1;
      check("reset.regwr_en",   32'(regwr_en),  32'd0);
      check("reset.regwr_sel",  32'(regwr_sel), 32'd0);
      check("reset.regwr_data", regwr_data,     32'd0);
      check("reset.busy",       busy,           32'd0);
      check("reset.sb_err",     32'(sb_err),    32'd0);
      rst = 1'b0;

      // Single EX write to a locked register
      lock_cycle(5'd5);
      check("t1.busy_lock", busy, 32'h0000_0020);
      ex_vld = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF;
      check_rdy("t1", 1'b1, 1'b0);
      expect_grant(5'd5, 32'hDEAD_BEEF);
      tick("t1");
      ex_vld = 1'b0;
      check("t1.busy", busy, 32'd0);
      check("t1.sb_err", 32'(sb_err), 32'd0);

      // Lock then LSU write clears the bit on the grant edge
      lock_cycle(5'd7);
      check("t2.busy_lock", busy, 32'h0000_0080);
      ls_vld = 1'b1; ls_rd = 5'd7; ls_data = 32'hCAFE_0007;
      check_rdy("t2", 1'b0, 1'b1);
      expect_grant(5'd7, 32'hCAFE_0007);
      tick("t2");
      ls_vld = 1'b0;
      check("t2.busy", busy, 32'd0);
      check("t2.sb_err", 32'(sb_err), 32'd0);

      // Starvation: LSU,LSU,LSU,EX,LSU then EX wins again only after count clears
      for (int r = 10; r <= 15; r++) lock_cycle(5'(r));
      check("t3.busy_lock", busy, 32'h0000_FC00);
      ex_vld = 1'b1; ex_rd = 5'd14; ex_data = 32'hE000_000E;
      ls_vld = 1'b1; ls_rd = 5'd10; ls_data = 32'hA000_000A;
      check_rdy("t3.c0", 1'b0, 1'b1);
      expect_grant(5'd10, 32'hA000_000A);
      tick("t3.c0");
      ls_rd = 5'd11; ls_data = 32'hA000_000B;
      check_rdy("t3.c1", 1'b0, 1'b1);
      expect_grant(5'd11, 32'hA000_000B);
      tick("t3.c1");
      ls_rd = 5'd12; ls_data = 32'hA000_000C;
      check_rdy("t3.c2", 1'b0, 1'b1);
      expect_grant(5'd12, 32'hA000_000C);
      tick("t3.c2");
      ls_rd = 5'd13; ls_data = 32'hA000_000D;
      check_rdy("t3.c3", 1'b1, 1'b0);
      expect_grant(5'd14, 32'hE000_000E);
      tick("t3.c3");
      ex_rd = 5'd15; ex_data = 32'hE000_000F;
      check_rdy("t3.c4", 1'b0, 1'b1);
      expect_grant(5'd13, 32'hA000_000D);
      tick("t3.c4");
      ls_vld = 1'b0;
      check_rdy("t3.c5", 1'b1, 1'b0);
      expect_grant(5'd15, 32'hE000_000F);
      tick("t3.c5");
      ex_vld = 1'b0;
      check("t3.busy", busy, 32'd0);
      check("t3.sb_err", 32'(sb_err), 32'd0);

      // Grant to x0 is consumed without a write; idle cycle holds sel/data
      lock_cycle(5'd2);
      ex_vld = 1'b1; ex_rd = 5'd0; ex_data = 32'h0000_1234;
      check_rdy("t4", 1'b1, 1'b0);
      expect_grant(5'd0, 32'h0000_1234);
      tick("t4");
      ex_vld = 1'b0;
      check("t4.busy", busy, 32'h0000_0004);
      check("t4.sb_err", 32'(sb_err), 32'd0);
      expect_idle();
      tick("t4.idle");
      ls_vld = 1'b1; ls_rd = 5'd2; ls_data = 32'h0000_0022;
      expect_grant(5'd2, 32'h0000_0022);
      tick("t4.clr");
      ls_vld = 1'b0;
      check("t4.busy_clr", busy, 32'd0);

      // Lock and clear of the same index: lock wins, no error; relock is WAW
      lock_cycle(5'd9);
      lock_en = 1'b1; lock_rd = 5'd9;
      ex_vld = 1'b1; ex_rd = 5'd9; ex_data = 32'h0000_0099;
      check_rdy("t5", 1'b1, 1'b0);
      expect_grant(5'd9, 32'h0000_0099);
      tick("t5");
      ex_vld = 1'b0;
      check("t5.busy", busy, 32'h0000_0200);
      check("t5.sb_err", 32'(sb_err), 32'd0);
      expect_idle();
      tick("t5.waw");
      lock_en = 1'b0;
      check("t5.waw_err", 32'(sb_err), 32'd1);
      check("t5.waw_busy", busy, 32'h0000_0200);
      expect_idle();
      tick("t5.sticky");
      check("t5.sticky_err", 32'(sb_err), 32'd1);

      // Async reset mid-stream with busy=0xF0 and a write in flight
      lock_cycle(5'd4);
      lock_cycle(5'd5);
      lock_cycle(5'd6);
      lock_en = 1'b1; lock_rd = 5'd7;
      ls_vld = 1'b1; ls_rd = 5'd9; ls_data = 32'h9999_0009;
      expect_grant(5'd9, 32'h9999_0009);
      tick("t6.pre");
      lock_en = 1'b0; ls_vld = 1'b0;
      check("t6.pre_busy", busy, 32'h0000_00F0);
      #2;
      rst = 1'b1;
      #1;
      check("t6.rst_regwr_en",   32'(regwr_en),  32'd0);
      check("t6.rst_regwr_sel",  32'(regwr_sel), 32'd0);
      check("t6.rst_regwr_data", regwr_data,     32'd0);
      check("t6.rst_busy",       busy,           32'd0);
      check("t6.rst_sb_err",     32'(sb_err),    32'd0);
      exp_q.delete();
      last_sel = '0; last_data = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      lock_cycle(5'd3);
      ls_vld = 1'b1; ls_rd = 5'd3; ls_data = 32'h3333_0003;
      check_rdy("t6.post", 1'b0, 1'b1);
      expect_grant(5'd3, 32'h3333_0003);
      tick("t6.post");
      ls_vld = 1'b0;
      check("t6.post_busy", busy, 32'd0);
      check("t6.post_sb_err", 32'(sb_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
